// File: rtl/ghr_spec_ckpt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ghr_spec_ckpt                                                  |
// | Purpose  : Speculative global history with in-order checkpoint recovery, |
// |            committed history copy and gshare PHT index generation.       |
// | Options  : GHR_PERF_CNT_EN adds saturating resolve/mispredict counters.  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module ghr_spec_ckpt #(
  parameter int HIST_LEN   = 8,
  parameter int CKPT_DEPTH = 4,
  parameter int INDEX_W    = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pred_valid,
  input  logic                            pred_taken,
  input  logic [31:0]                     pred_pc,
  output logic                            pred_ready,
  output logic [INDEX_W-1:0]              pred_index,
  input  logic                            res_valid,
  input  logic                            res_taken,
  input  logic                            res_mispredict,
  output logic [HIST_LEN-1:0]             spec_hist,
  output logic [HIST_LEN-1:0]             commit_hist,
  output logic [$clog2(CKPT_DEPTH+1)-1:0] ckpt_count
`ifdef GHR_PERF_CNT_EN
  ,
  output logic [31:0]                     perf_resolved,
  output logic [31:0]                     perf_mispred
`endif
);

  localparam int c_cnt_w   = $clog2(CKPT_DEPTH + 1);
  localparam int c_ptr_w   = $clog2(CKPT_DEPTH);
  localparam int c_n_chunk = (HIST_LEN + INDEX_W - 1) / INDEX_W;
  localparam int c_pad_w   = c_n_chunk * INDEX_W;
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(CKPT_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(CKPT_DEPTH - 1);

  logic [HIST_LEN-1:0] r_ckpt [CKPT_DEPTH];
  logic [c_ptr_w-1:0]  r_head;
  logic [c_ptr_w-1:0]  r_tail;
  logic [c_cnt_w-1:0]  r_count;
  logic [HIST_LEN-1:0] r_spec_hist;
  logic [HIST_LEN-1:0] r_commit_hist;

  logic                w_push;
  logic                w_pop;
  logic                w_mispred;
  logic [HIST_LEN-1:0] w_restore;
  logic [c_pad_w-1:0]  w_hist_pad;
  logic [INDEX_W-1:0]  w_fold;
  logic                w_unused_pc;

  assign pred_ready  = (r_count != c_depth);
  assign w_pop       = res_valid && (r_count != '0);
  assign w_mispred   = w_pop && res_mispredict;
  // A wrong-path prediction arriving with the mispredict is simply never accepted.
  assign w_push      = pred_valid && pred_ready && !w_mispred;
  assign w_restore   = {r_ckpt[r_head][HIST_LEN-2:0], res_taken};

  assign spec_hist   = r_spec_hist;
  assign commit_hist = r_commit_hist;
  assign ckpt_count  = r_count;

  // Long histories are folded into INDEX_W-bit chunks; the top chunk is zero-padded.
  generate
    if (c_pad_w > HIST_LEN) begin : g_pad
      assign w_hist_pad = {{(c_pad_w - HIST_LEN){1'b0}}, r_spec_hist};
    end else begin : g_nopad
      assign w_hist_pad = r_spec_hist;
    end
  endgenerate

  always_comb begin
    w_fold = '0;
    for (int i = 0; i < c_n_chunk; i++) begin
      w_fold = w_fold ^ w_hist_pad[i*INDEX_W +: INDEX_W];
    end
  end

  assign pred_index  = pred_pc[INDEX_W+1:2] ^ w_fold;
  assign w_unused_pc = ^pred_pc;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ckpt[r_tail] <= r_spec_hist;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_spec_hist   <= '0;
      r_commit_hist <= '0;
    end else begin
      if (w_pop) begin
        r_commit_hist <= {r_commit_hist[HIST_LEN-2:0], res_taken};
      end
      if (w_mispred) begin
        r_spec_hist <= w_restore;
        r_head      <= '0;
        r_tail      <= '0;
        r_count     <= '0;
      end else begin
        if (w_push) begin
          r_spec_hist <= {r_spec_hist[HIST_LEN-2:0], pred_taken};
          r_tail      <= (r_tail == c_ptr_last) ? '0 : r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= (r_head == c_ptr_last) ? '0 : r_head + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

`ifdef GHR_PERF_CNT_EN
  logic [31:0] r_perf_resolved;
  logic [31:0] r_perf_mispred;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_resolved <= '0;
      r_perf_mispred  <= '0;
    end else begin
      if (w_pop && (r_perf_resolved != 32'hFFFF_FFFF)) begin
        r_perf_resolved <= r_perf_resolved + 32'd1;
      end
      if (w_mispred && (r_perf_mispred != 32'hFFFF_FFFF)) begin
        r_perf_mispred <= r_perf_mispred + 32'd1;
      end
    end
  end

  assign perf_resolved = r_perf_resolved;
  assign perf_mispred  = r_perf_mispred;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ghr_spec_ckpt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ghr_spec_ckpt                                               |
// | Purpose  : Scoreboard bench for ghr_spec_ckpt against a queue model.     |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ghr_spec_ckpt;

  localparam int HL    = 8;
  localparam int IW    = 10;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [HL-1:0] spec;
    logic [HL-1:0] commit;
    logic [2:0]    cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        pred_ready;
  logic [IW-1:0] pred_index;
  logic        res_valid;
  logic        res_taken;
  logic        res_mispredict;
  logic [HL-1:0] spec_hist;
  logic [HL-1:0] commit_hist;
  logic [2:0]  ckpt_count;

  logic          pred_ready16;
  logic [IW-1:0] pred_index16;
  logic [15:0]   spec_hist16;
  logic [15:0]   commit_hist16;
  logic [2:0]    ckpt_count16;

  int checks = 0;
  int errors = 0;

  logic [HL-1:0] q_ckpt[$];
  logic [HL-1:0] m_spec;
  logic [HL-1:0] m_commit;
  exp_t          exp_q[$];
  exp_t          e;

  ghr_spec_ckpt #(.HIST_LEN(HL), .CKPT_DEPTH(DEPTH), .INDEX_W(IW)) u_dut (
    .clk(clk), .rst(rst_n), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_pc(pred_pc), .pred_ready(pred_ready), .pred_index(pred_index),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .spec_hist(spec_hist), .commit_hist(commit_hist), .ckpt_count(ckpt_count)
  );

  ghr_spec_ckpt #(.HIST_LEN(16), .CKPT_DEPTH(DEPTH), .INDEX_W(IW)) u_dut16 (
    .clk(clk), .rst(rst_n), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_pc(pred_pc), .pred_ready(pred_ready16), .pred_index(pred_index16),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .spec_hist(spec_hist16), .commit_hist(commit_hist16), .ckpt_count(ckpt_count16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Each history bit i lands on index bit (i mod IW).
  function automatic logic [IW-1:0] exp_index(input logic [31:0] pc, input logic [HL-1:0] h);
    logic [IW-1:0] r;
    r = pc[IW+1:2];
    for (int i = 0; i < HL; i++) r[i % IW] = r[i % IW] ^ h[i];
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("spec_hist", 32'(spec_hist), 32'(e.spec));
      chk("commit_hist", 32'(commit_hist), 32'(e.commit));
      chk("ckpt_count", 32'(ckpt_count), 32'(e.cnt));
    end
  end

  task automatic step(input bit pv, input bit pt, input logic [31:0] pc,
                      input bit rv, input bit rt, input bit rm);
    bit ready;
    bit push;
    bit pop;
    logic [HL-1:0] old;
    pred_valid = pv; pred_taken = pt; pred_pc = pc;
    res_valid = rv; res_taken = rt; res_mispredict = rm;
    #1;
    ready = (q_ckpt.size() != DEPTH);
    chk("pred_ready", 32'(pred_ready), 32'(ready));
    chk("pred_index", 32'(pred_index), 32'(exp_index(pc, m_spec)));
    push = pv && ready;
    pop  = rv && (q_ckpt.size() != 0);
    if (pop && rm) begin
      old      = q_ckpt[0];
      m_spec   = {old[HL-2:0], rt};
      m_commit = {m_commit[HL-2:0], rt};
      q_ckpt.delete();
    end else begin
      if (pop) begin
        old      = q_ckpt.pop_front();
        m_commit = {m_commit[HL-2:0], rt};
      end
      if (push) begin
        q_ckpt.push_back(m_spec);
        m_spec = {m_spec[HL-2:0], pt};
      end
    end
    exp_q.push_back('{spec: m_spec, commit: m_commit, cnt: 3'(q_ckpt.size())});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
    #1;
    chk("rst_spec", 32'(spec_hist), 32'h0);
    chk("rst_commit", 32'(commit_hist), 32'h0);
    chk("rst_count", 32'(ckpt_count), 32'h0);
    chk("rst_ready", 32'(pred_ready), 32'h1);
    q_ckpt.delete();
    m_spec = '0;
    m_commit = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0; pred_valid = 0; pred_taken = 0; pred_pc = 0;
    res_valid = 0; res_taken = 0; res_mispredict = 0;
    m_spec = '0; m_commit = '0;
    @(negedge clk);
    do_reset();

    // T,N,T then three correct resolves
    step(1, 1, $urandom, 0, 0, 0);
    step(1, 0, $urandom, 0, 0, 0);
    step(1, 1, $urandom, 0, 0, 0);
    chk("tnt_spec", 32'(spec_hist), 32'h05);
    step(0, 0, $urandom, 1, 1, 0);
    step(0, 0, $urandom, 1, 0, 0);
    step(0, 0, $urandom, 1, 1, 0);
    chk("tnt_commit", 32'(commit_hist), 32'h05);
    chk("tnt_count", 32'(ckpt_count), 32'h0);

    // Fill the queue, then push against a full queue
    for (int i = 0; i < 4; i++) step(1, 1, $urandom, 0, 0, 0);
    chk("full_ready", 32'(pred_ready), 32'h0);
    step(1, 0, $urandom, 0, 0, 0);
    chk("full_spec", 32'(spec_hist), 32'h5F);
    chk("full_count", 32'(ckpt_count), 32'h4);
    step(1, 0, $urandom, 1, 1, 0);
    chk("deq_count", 32'(ckpt_count), 32'h3);
    step(1, 0, $urandom, 1, 1, 0);
    chk("pushpop_count", 32'(ckpt_count), 32'h3);

    // Asynchronous reset with three checkpoints occupied
    do_reset();

    // T,T,T then mispredict not-taken
    for (int i = 0; i < 3; i++) step(1, 1, $urandom, 0, 0, 0);
    chk("ttt_spec", 32'(spec_hist), 32'h07);
    step(0, 0, $urandom, 1, 0, 1);
    chk("mis_spec", 32'(spec_hist), 32'h00);
    chk("mis_commit", 32'(commit_hist), 32'h00);
    chk("mis_count", 32'(ckpt_count), 32'h0);
    chk("mis_ready", 32'(pred_ready), 32'h1);

    // Mispredict and prediction together: prediction dropped
    step(1, 1, $urandom, 0, 0, 0);
    step(1, 0, $urandom, 0, 0, 0);
    step(1, 1, $urandom, 1, 1, 1);
    chk("mis_pred_spec", 32'(spec_hist), 32'h01);
    chk("mis_pred_count", 32'(ckpt_count), 32'h0);

    // Build 8'hA5 and check the worked index example
    do_reset();
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) step(1, pat[i], $urandom, i != 7, $urandom_range(0, 1), 0);
    chk("a5_spec", 32'(spec_hist), 32'hA5);
    pred_valid = 0; res_valid = 0; pred_pc = 32'h0000_1234;
    #1;
    chk("a5_index", 32'(pred_index), 32'h028);
    @(negedge clk);

    // 16-bit history folding
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 1, 32'h0, 1, 1, 0);
    pred_valid = 0; res_valid = 0; pred_pc = 32'h0;
    #1;
    chk("h16_spec", 32'(spec_hist16), 32'hFFFF);
    chk("h16_index", 32'(pred_index16), 32'h3C0);
    @(negedge clk);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, 7) == 0);
    end
    step(0, 0, 32'h0, 0, 0, 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
